regfile_wr_arbiter: RTL and testbench

Shares the single register-file write port (RegWrite/RegWrAddr/RegWrData, committed by the register file on the falling clock edge) between the in-order pipeline writeback stage and a long-latency unit (mult/div, cache-miss load return). It also keeps a per-register busy scoreboard for outstanding long-latency results so issue logic can stall dependent instructions. The block is fully synchronous to the pipeline clock and registers all of its outputs.

---
 rtl/mips_pkg.sv | 31 +++
 rtl/regfile_wr_arbiter_if.sv | 63 ++++++
 rtl/wr_fifo2.sv | 48 ++++
 rtl/regfile_wr_arbiter.sv | 133 +++++++++++++
 tb/tb_regfile_wr_arbiter.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared types for the register-file write path: widths, the
// {addr, data} write request and the write-port grant encoding.
package mips_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam int NUM_REGS   = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0]     data_t;
    typedef logic [NUM_REGS-1:0]   reg_vec_t;

    typedef struct packed {
        reg_addr_t addr;
        data_t     data;
    } wr_req_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_P    = 2'd1,
        GNT_L    = 2'd2
    } grant_t;

    function automatic reg_vec_t reg_bit(input reg_addr_t a);
        reg_vec_t v;
        v = '0;
        v[a] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/regfile_wr_arbiter_if.sv
// Bundle of writeback, long-latency, issue and register-file
// write-port signals around the write arbiter.
interface regfile_wr_arbiter_if;

    import mips_pkg::*;

    logic      PWrEn;
    reg_addr_t PWrAddr;
    data_t     PWrData;

    logic      LValid;
    logic      LReady;
    reg_addr_t LAddr;
    data_t     LData;

    logic      LIssue;
    reg_addr_t LIssueAddr;

    logic      RegWrite;
    reg_addr_t RegWrAddr;
    data_t     RegWrData;

    reg_vec_t  BusyVec;
    logic      StallReq;
    logic      ProtoErr;

    modport master (
        output PWrEn,
        output PWrAddr,
        output PWrData,
        output LValid,
        input  LReady,
        output LAddr,
        output LData,
        output LIssue,
        output LIssueAddr,
        input  RegWrite,
        input  RegWrAddr,
        input  RegWrData,
        input  BusyVec,
        input  StallReq,
        input  ProtoErr
    );

    modport slave (
        input  PWrEn,
        input  PWrAddr,
        input  PWrData,
        input  LValid,
        output LReady,
        input  LAddr,
        input  LData,
        input  LIssue,
        input  LIssueAddr,
        output RegWrite,
        output RegWrAddr,
        output RegWrData,
        output BusyVec,
        output StallReq,
        output ProtoErr
    );

endinterface

// File: rtl/wr_fifo2.sv
// Two-entry synchronous FIFO of write requests with full/empty flags.
module wr_fifo2
    import mips_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  logic    push,
    input  wr_req_t push_req,
    input  logic    pop,
    output wr_req_t head,
    output logic    full,
    output logic    empty
);

    wr_req_t    mem [2];
    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] count;
    logic       do_push;
    logic       do_pop;

    assign full    = (count == 2'd2);
    assign empty   = (count == 2'd0);
    assign do_pop  = pop && !empty;
    // A full FIFO can still take a push when the head leaves this cycle
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
            mem[0] <= '0;
            mem[1] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_req;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + 2'(do_push) - 2'(do_pop);
        end
    end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Register-file write-port arbiter: writeback first, long-latency FIFO
// otherwise, with starvation stall request and busy scoreboard.
module regfile_wr_arbiter
    import mips_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input logic                 Clk,
    input logic                 Rst_n,
    regfile_wr_arbiter_if.slave bus
);

    localparam logic [2:0] LIMIT   = 3'(STARVE_LIMIT);
    localparam logic [2:0] CNT_MAX = 3'd7;

    wr_req_t    head;
    wr_req_t    l_req;
    wr_req_t    win;
    grant_t     grant;
    logic       full;
    logic       empty;
    logic       push;
    logic       pop;

    logic       wr_q;
    reg_addr_t  addr_q;
    data_t      data_q;
    reg_vec_t   busy_q;
    reg_vec_t   busy_next;
    logic [2:0] starve_q;
    logic [2:0] starve_next;
    logic       stall_q;
    logic       stall_next;
    logic       stall_prev_q;
    logic       err_q;
    logic       err_next;

    assign l_req = '{addr: bus.LAddr, data: bus.LData};
    assign push  = bus.LValid && !full;
    assign pop   = (grant == GNT_L);

    wr_fifo2 u_fifo (
        .clk      (Clk),
        .rst_n    (Rst_n),
        .push     (push),
        .push_req (l_req),
        .pop      (pop),
        .head     (head),
        .full     (full),
        .empty    (empty)
    );

    always_comb begin
        grant = GNT_NONE;
        if (bus.PWrEn) begin
            grant = GNT_P;
        end else if (!empty) begin
            grant = GNT_L;
        end
    end

    always_comb begin
        win = '0;
        unique case (grant)
            GNT_P:   win = '{addr: bus.PWrAddr, data: bus.PWrData};
            GNT_L:   win = head;
            default: win = '0;
        endcase
    end

    // Issue is applied after the clear so a same-cycle set wins
    always_comb begin
        busy_next = busy_q;
        if (grant == GNT_L) begin
            busy_next = busy_next & ~reg_bit(head.addr);
        end
        if (bus.LIssue) begin
            busy_next = busy_next | reg_bit(bus.LIssueAddr);
        end
        busy_next[0] = 1'b0;
    end

    always_comb begin
        starve_next = starve_q;
        if (empty || pop) begin
            starve_next = '0;
        end else if (starve_q != CNT_MAX) begin
            starve_next = starve_q + 3'd1;
        end
    end

    assign stall_next = (starve_next >= LIMIT);
    assign err_next   = err_q | (bus.PWrEn & stall_prev_q);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            wr_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            wr_q <= (grant != GNT_NONE) && (win.addr != '0);
            if (grant != GNT_NONE) begin
                addr_q <= win.addr;
                data_q <= win.data;
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            busy_q       <= '0;
            starve_q     <= '0;
            stall_q      <= 1'b0;
            stall_prev_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            busy_q       <= busy_next;
            starve_q     <= starve_next;
            stall_q      <= stall_next;
            stall_prev_q <= stall_q;
            err_q        <= err_next;
        end
    end

    assign bus.LReady    = !full;
    assign bus.RegWrite  = wr_q;
    assign bus.RegWrAddr = addr_q;
    assign bus.RegWrData = data_q;
    assign bus.BusyVec   = busy_q;
    assign bus.StallReq  = stall_q;
    assign bus.ProtoErr  = err_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Bench for regfile_wr_arbiter: queue-based reference model checked
// every cycle plus directed literal expectations.
module tb_regfile_wr_arbiter;

    localparam int LIMIT = 4;

    logic clk;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;

    regfile_wr_arbiter_if bus ();

    regfile_wr_arbiter #(
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .Clk   (clk),
        .Rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t",
                     name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.PWrEn      = 1'b0;
        bus.PWrAddr    = '0;
        bus.PWrData    = '0;
        bus.LValid     = 1'b0;
        bus.LAddr      = '0;
        bus.LData      = '0;
        bus.LIssue     = 1'b0;
        bus.LIssueAddr = '0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_regwrite"}, 32'(bus.RegWrite), 0);
        chk({tag, "_wraddr"}, 32'(bus.RegWrAddr), 0);
        chk({tag, "_wrdata"}, bus.RegWrData, 0);
        chk({tag, "_busy"}, bus.BusyVec, 0);
        chk({tag, "_stall"}, 32'(bus.StallReq), 0);
        chk({tag, "_err"}, 32'(bus.ProtoErr), 0);
        chk({tag, "_lready"}, 32'(bus.LReady), 1);
    endtask

    // Reference model: queue FIFO and per-register busy flags
    logic        m_wr;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    logic [31:0] m_busy;
    logic        m_stall;
    logic        m_prev;
    logic        m_err;
    int          m_cnt;
    logic [4:0]  qa[$];
    logic [31:0] qd[$];
    bit          m_rdy;
    bit          m_had;
    bit          m_pop;
    logic [4:0]  ta;
    logic [31:0] td;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_wr = 0; m_addr = 0; m_data = 0; m_busy = 0;
            m_stall = 0; m_prev = 0; m_err = 0; m_cnt = 0;
            qa.delete();
            qd.delete();
        end else begin
            m_rdy = qa.size() < 2;
            m_had = qa.size() > 0;
            m_pop = 0;
            if (bus.PWrEn && m_prev) m_err = 1;
            m_prev = m_stall;
            m_wr = 0;
            if (bus.PWrEn) begin
                m_wr = bus.PWrAddr != 0;
                m_addr = bus.PWrAddr;
                m_data = bus.PWrData;
            end else if (m_had) begin
                ta = qa.pop_front();
                td = qd.pop_front();
                m_pop = 1;
                m_wr = ta != 0;
                m_addr = ta;
                m_data = td;
                m_busy[ta] = 0;
            end
            if (bus.LIssue) m_busy[bus.LIssueAddr] = 1;
            m_busy[0] = 0;
            if (bus.LValid && m_rdy) begin
                qa.push_back(bus.LAddr);
                qd.push_back(bus.LData);
            end
            if (m_had && !m_pop) m_cnt = (m_cnt < 7) ? m_cnt + 1 : 7;
            else m_cnt = 0;
            m_stall = m_cnt >= LIMIT;
        end
    end

    initial forever begin
        @(negedge clk);
        chk("m_regwrite", 32'(bus.RegWrite), 32'(m_wr));
        if (m_wr) begin
            chk("m_wraddr", 32'(bus.RegWrAddr), 32'(m_addr));
            chk("m_wrdata", bus.RegWrData, m_data);
        end
        chk("m_busy", bus.BusyVec, m_busy);
        chk("m_stall", 32'(bus.StallReq), 32'(m_stall));
        chk("m_err", 32'(bus.ProtoErr), 32'(m_err));
        chk("m_lready", 32'(bus.LReady), 32'(qa.size() < 2));
    end

    initial begin
        rst_n = 1'b1;
        idle();
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk_reset("rst");
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Writeback path latency
        tick();
        bus.PWrEn = 1'b1; bus.PWrAddr = 5'd5; bus.PWrData = 32'hDEADBEEF;
        #1 chk("p_pre_wr", 32'(bus.RegWrite), 0);
        tick();
        idle();
        #1;
        chk("p_wr", 32'(bus.RegWrite), 1);
        chk("p_addr", 32'(bus.RegWrAddr), 5);
        chk("p_data", bus.RegWrData, 32'hDEADBEEF);

        // Busy bit lifetime around a long-latency result
        tick();
        bus.LIssue = 1'b1; bus.LIssueAddr = 5'd9;
        tick();
        idle();
        #1 chk("busy_set", bus.BusyVec, 32'h0000_0200);
        tick();
        tick();
        bus.LValid = 1'b1; bus.LAddr = 5'd9; bus.LData = 32'h12345678;
        tick();
        idle();
        #1;
        chk("busy_hold", bus.BusyVec, 32'h0000_0200);
        chk("l_no_bypass", 32'(bus.RegWrite), 0);
        tick();
        #1;
        chk("l_wr", 32'(bus.RegWrite), 1);
        chk("l_addr", 32'(bus.RegWrAddr), 9);
        chk("l_data", bus.RegWrData, 32'h12345678);
        chk("busy_clr", bus.BusyVec, 0);

        // Starvation under continuous writeback
        tick();
        bus.PWrEn = 1'b1; bus.PWrAddr = 5'd1; bus.PWrData = 32'h100;
        bus.LValid = 1'b1; bus.LAddr = 5'd10; bus.LData = 32'hA0;
        tick();
        bus.PWrData = 32'h101; bus.LAddr = 5'd11; bus.LData = 32'hA1;
        tick();
        bus.PWrData = 32'h102; bus.LAddr = 5'd12; bus.LData = 32'hA2;
        #1 chk("l_full_ready", 32'(bus.LReady), 0);
        tick();
        bus.LValid = 1'b0; bus.PWrData = 32'h103;
        tick();
        #1 chk("stall_early", 32'(bus.StallReq), 0);
        tick();
        #1 chk("stall_rise", 32'(bus.StallReq), 1);
        tick();
        bus.PWrEn = 1'b0;
        tick();
        #1;
        chk("starve_wr", 32'(bus.RegWrite), 1);
        chk("starve_addr", 32'(bus.RegWrAddr), 10);
        chk("starve_data", bus.RegWrData, 32'hA0);
        chk("starve_stall_clr", 32'(bus.StallReq), 0);
        tick();
        #1;
        chk("starve2_addr", 32'(bus.RegWrAddr), 11);
        chk("starve2_data", bus.RegWrData, 32'hA1);
        chk("starve_no_err", 32'(bus.ProtoErr), 0);

        // Stall ignored by the pipeline
        tick();
        bus.PWrEn = 1'b1; bus.PWrAddr = 5'd2; bus.PWrData = 32'h200;
        bus.LValid = 1'b1; bus.LAddr = 5'd13; bus.LData = 32'hB0;
        tick();
        bus.LValid = 1'b0;
        repeat (4) tick();
        #1;
        chk("viol_stall", 32'(bus.StallReq), 1);
        chk("viol_err_pre", 32'(bus.ProtoErr), 0);
        tick();
        bus.PWrData = 32'h2EE;
        tick();
        bus.PWrEn = 1'b0;
        #1;
        chk("viol_p_wr", 32'(bus.RegWrite), 1);
        chk("viol_p_addr", 32'(bus.RegWrAddr), 2);
        chk("viol_p_data", bus.RegWrData, 32'h2EE);
        chk("viol_err", 32'(bus.ProtoErr), 1);
        chk("viol_fifo", 32'(bus.LReady), 1);
        tick();
        #1 chk("viol_l_addr", 32'(bus.RegWrAddr), 13);
        repeat (3) tick();
        #1 chk("err_sticky", 32'(bus.ProtoErr), 1);

        // Register 0 writes are dropped but still drain the FIFO
        tick();
        bus.PWrEn = 1'b1; bus.PWrAddr = 5'd0; bus.PWrData = 32'h55;
        bus.LValid = 1'b1; bus.LAddr = 5'd0; bus.LData = 32'h66;
        bus.LIssue = 1'b1; bus.LIssueAddr = 5'd0;
        tick();
        idle();
        bus.LValid = 1'b1; bus.LAddr = 5'd3; bus.LData = 32'h33;
        #1 chk("r0_p_drop", 32'(bus.RegWrite), 0);
        tick();
        idle();
        #1;
        chk("r0_l_drop", 32'(bus.RegWrite), 0);
        chk("r0_busy", bus.BusyVec, 0);
        tick();
        #1;
        chk("r0_next_wr", 32'(bus.RegWrite), 1);
        chk("r0_next_addr", 32'(bus.RegWrAddr), 3);

        // Issue and retire of the same register in one cycle
        tick();
        bus.LValid = 1'b1; bus.LAddr = 5'd7; bus.LData = 32'h77;
        bus.LIssue = 1'b1; bus.LIssueAddr = 5'd7;
        tick();
        bus.LValid = 1'b0;
        tick();
        idle();
        #1;
        chk("same_wr_addr", 32'(bus.RegWrAddr), 7);
        chk("same_busy", bus.BusyVec, 32'h0000_0080);

        // Asynchronous reset with work in flight
        tick();
        bus.PWrEn = 1'b1; bus.PWrAddr = 5'd4; bus.PWrData = 32'h44;
        bus.LValid = 1'b1; bus.LAddr = 5'd20; bus.LData = 32'h2020;
        bus.LIssue = 1'b1; bus.LIssueAddr = 5'd20;
        tick();
        bus.LAddr = 5'd21; bus.LData = 32'h2121;
        bus.LIssueAddr = 5'd21; bus.PWrData = 32'h45;
        tick();
        idle();
        #2 rst_n = 1'b0;
        #1 chk_reset("mid_rst");
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) tick();
        #1;
        chk("post_rst_wr", 32'(bus.RegWrite), 0);
        chk("post_rst_busy", bus.BusyVec, 0);

        repeat (2) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
